// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the multi-channel pulse generator.
package pulse_gen_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_TICK   = 1'b1
  } pulse_mode_e;

  localparam int unsigned CNT_W_DEF        = 25;
  localparam int unsigned DEFAULT_HALF_DEF = 800000;
  localparam int unsigned HALF_MAX_W       = 64;

  // A half-period of zero would never reach terminal count; treat it as one.
  function automatic logic [HALF_MAX_W-1:0] clamp_half(input logic [HALF_MAX_W-1:0] v);
    return (v == '0) ? HALF_MAX_W'(1) : v;
  endfunction

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: counter, active/shadow settings, pending flag, output flop.
// MULTI_PERIOD_PULSE_GEN_SYNC_EN enables the sync realignment strobe.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             acc,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_mode,
  input  logic             sync,
  output logic             out,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_HALF =
    CNT_W'(clamp_half(HALF_MAX_W'(DEFAULT_HALF)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] sh_half;
  pulse_mode_e      mode;
  pulse_mode_e      sh_mode;
  logic             term;

  assign term = en && (cnt == half - CNT_W'(1));

`ifndef MULTI_PERIOD_PULSE_GEN_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      half    <= RST_HALF;
      sh_half <= RST_HALF;
      mode    <= MODE_SQUARE;
      sh_mode <= MODE_SQUARE;
      pending <= 1'b0;
      out     <= 1'b0;
    end else begin
`ifdef MULTI_PERIOD_PULSE_GEN_SYNC_EN
      // Realign: restart counting, drain any pending shadow, keep a fresh accept pending.
      if (sync) begin
        cnt <= '0;
        out <= 1'b0;
        if (pending) begin
          half    <= sh_half;
          mode    <= sh_mode;
          pending <= 1'b0;
        end
        if (acc) begin
          sh_half <= CNT_W'(clamp_half(HALF_MAX_W'(cfg_half)));
          sh_mode <= pulse_mode_e'(cfg_mode);
          pending <= 1'b1;
        end
      end else
`endif
      begin
        // acc implies !pending, so it never collides with an apply below.
        if (acc) begin
          sh_half <= CNT_W'(clamp_half(HALF_MAX_W'(cfg_half)));
          sh_mode <= pulse_mode_e'(cfg_mode);
          pending <= 1'b1;
        end
        if (en) begin
          if (term) begin
            cnt <= '0;
            if (pending) begin
              half    <= sh_half;
              mode    <= sh_mode;
              pending <= 1'b0;
            end
            if (pending && (sh_mode != mode)) begin
              out <= 1'b0;
            end else if (mode == MODE_TICK) begin
              out <= 1'b1;
            end else begin
              out <= ~out;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (mode == MODE_TICK) out <= 1'b0;
          end
        end else if (pending) begin
          half    <= sh_half;
          mode    <= sh_mode;
          pending <= 1'b0;
          cnt     <= '0;
          out     <= 1'b0;
        end else if (mode == MODE_TICK) begin
          out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/multi_period_pulse_gen.sv
// Multi-channel periodic pulse generator: cfg decode, ready mux and sync fan-out.
// MULTI_PERIOD_PULSE_GEN_SYNC_EN (in pulse_gen_channel) makes sync functional.
module multi_period_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_mode,
  input  logic              sync,
  output logic [NUM_CH-1:0] out
);

  localparam int unsigned CH_N = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] acc;
  logic [CH_N-1:0]   pend_ext;

  // Padded so out-of-range channel codes index a defined bit.
  assign pend_ext  = CH_N'(pending);
  assign cfg_ready = ~pend_ext[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign acc[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    pulse_gen_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .acc     (acc[i]),
      .cfg_half(cfg_half),
      .cfg_mode(cfg_mode),
      .sync    (sync),
      .out     (out[i]),
      .pending (pending[i])
    );
  end

endmodule

// File: tb/tb_multi_period_pulse_gen.sv
// Directed, table-driven bench for multi_period_pulse_gen (4 channels, half 4 at reset).
module tb_multi_period_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_half;
  logic       cfg_mode;
  logic       sync;
  logic [3:0] out;

  always #5 clk = ~clk;

  multi_period_pulse_gen #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEFAULT_HALF(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .cfg_mode (cfg_mode),
    .sync     (sync),
    .out      (out)
  );

  typedef struct {
    logic [3:0] en;
    logic       v;
    logic [1:0] ch;
    logic [7:0] half;
    logic       mode;
    logic [3:0] exp_out;
    logic       exp_rdy;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input logic [3:0] e, input logic v, input logic [1:0] ch,
                     input logic [7:0] h, input logic m, input logic [3:0] eo,
                     input logic er);
    vec_t r;
    r.en = e; r.v = v; r.ch = ch; r.half = h; r.mode = m;
    r.exp_out = eo; r.exp_rdy = er;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_mode = 1'b0; sync = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_out", 32'(out), 32'h0);
    check("reset_rdy", 32'(cfg_ready), 32'h1);
    rst = 1'b1;
  endtask

  task automatic run(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      en = vq[i].en; cfg_valid = vq[i].v; cfg_ch = vq[i].ch;
      cfg_half = vq[i].half; cfg_mode = vq[i].mode;
      @(posedge clk); #1;
      check($sformatf("%s[%0d].out", tag, i - lo), 32'(out), 32'(vq[i].exp_out));
      check($sformatf("%s[%0d].rdy", tag, i - lo), 32'(cfg_ready), 32'(vq[i].exp_rdy));
    end
  endtask

  task automatic step_check(input string name, input logic [3:0] eo);
    @(posedge clk); #1;
    check(name, 32'(out), 32'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pa, pb, pc, pd, pe, pf, pg;

    // A: square on ch0, half 4 from reset -> toggles on edges 4, 8, 12
    pa = vq.size();
    for (int k = 1; k <= 12; k++)
      add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0,
          ((k >= 4 && k <= 7) || k >= 12) ? 4'b0001 : 4'b0000, 1'b1);
    // B: ch1 tick, half 3, configured while disabled then enabled
    pb = vq.size();
    add(4'b0000, 1'b1, 2'd1, 8'd3, 1'b1, 4'b0000, 1'b0);
    add(4'b0000, 1'b0, 2'd1, 8'd0, 1'b0, 4'b0000, 1'b1);
    for (int k = 1; k <= 9; k++)
      add(4'b0010, 1'b0, 2'd1, 8'd0, 1'b0, (k % 3 == 0) ? 4'b0010 : 4'b0000, 1'b1);
    // C: ch0 reconfig to half 2 at count 1; blocked second request; ch2 accepted concurrently
    pc = vq.size();
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b1, 2'd0, 8'd2, 1'b0, 4'b0000, 1'b0);
    add(4'b0001, 1'b1, 2'd0, 8'd7, 1'b0, 4'b0000, 1'b0);
    add(4'b0001, 1'b1, 2'd2, 8'd5, 1'b0, 4'b0001, 1'b0);
    add(4'b0001, 1'b0, 2'd2, 8'd0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    // D: ch3 half 0 (stored as 1) square toggles every cycle, holds while disabled
    pd = vq.size();
    add(4'b0000, 1'b1, 2'd3, 8'd0, 1'b0, 4'b0000, 1'b0);
    add(4'b0000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b1000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b1000, 1'b1);
    add(4'b1000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b1000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b1000, 1'b1);
    add(4'b0000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b1000, 1'b1);
    add(4'b0000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b1000, 1'b1);
    add(4'b1000, 1'b0, 2'd3, 8'd0, 1'b0, 4'b0000, 1'b1);
    // E: drop en mid-count on ch0, resume finishes remaining cycles
    pe = vq.size();
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0000, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    // F: ch0 square -> tick half 2; mode change forces out low at the apply terminal
    pf = vq.size();
    add(4'b0001, 1'b1, 2'd0, 8'd2, 1'b1, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b0);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0000, 1'b1);
    add(4'b0001, 1'b0, 2'd0, 8'd0, 1'b0, 4'b0001, 1'b1);
    pg = vq.size();

    do_reset(); run(pa, pb, "sq_default");
    do_reset(); run(pb, pc, "tick_ch1");
    do_reset(); run(pc, pd, "reconfig");
    do_reset(); run(pd, pe, "half_zero");
    do_reset(); run(pe, pf, "en_hold");
    do_reset(); run(pf, pg, "mode_change");

    // Async reset mid-cycle clears outputs without a clock edge
    do_reset();
    en = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    check("async_pre", 32'(out), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_out", 32'(out), 32'h0);
    check("async_rdy", 32'(cfg_ready), 32'h1);
    step_check("async_hold", 4'b0000);
    rst = 1'b1;

`ifdef MULTI_PERIOD_PULSE_GEN_SYNC_EN
    // Misaligned channels realigned by sync; ch0 was at terminal when sync hit
    do_reset();
    en = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    en = 4'b1111;
    @(posedge clk); #1;
    sync = 1'b1;
    step_check("sync_edge", 4'b0000);
    sync = 1'b0;
    step_check("sync_c1", 4'b0000);
    step_check("sync_c2", 4'b0000);
    step_check("sync_c3", 4'b0000);
    step_check("sync_c4", 4'b1111);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_period_pulse_gen.md
# multi_period_pulse_gen

- Parametrised, multi-channel periodic pulse generator, next generation of the team's fixed half-second toggler.
- Each of `NUM_CH` channels has its own runtime-programmable half-period, an enable, and a mode: square-wave toggle or single-cycle tick.
- Reconfiguration uses a valid/ready handshake. New settings take effect only at a channel's terminal count, so outputs never glitch.
- Sits beside the board clock as the common time-base source for LED blinkers, debouncers and slow-polling logic.

## Interface

Parameters:
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 25: counter and half-period width.
- `DEFAULT_HALF`, 800000: half-period loaded into every channel at reset.

Ports:
- `clk`  in  1: single clock; every flop is on its rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `en`  in  `NUM_CH`: per-channel run enable.
- `cfg_valid`  in  1: configuration request.
- `cfg_ready`  out  1: configuration can be accepted.
- `cfg_ch`  in  `$clog2(NUM_CH)` (min 1): target channel.
- `cfg_half`  in  `CNT_W`: new half-period in cycles.
- `cfg_mode`  in  1: 0 = square, 1 = tick.
- `sync`  in  1: phase realignment strobe; functional only with the macro enabled.
- `out`  out  `NUM_CH`: registered channel outputs.

## Operation

Reset (`rst` low, asynchronous):
- All counters = 0, `out` = 0, half = `DEFAULT_HALF`, mode = square.
- Pending flags cleared; `cfg_ready` = 1.

Per channel `i`, when `en[i]` = 1:
- Counter increments each cycle.
- At count == half−1 (terminal), the counter wraps to 0.
- Square mode: `out[i]` toggles at terminal. Period = 2×half cycles.
- Tick mode: `out[i]` = 1 for exactly the one cycle after terminal, 0 otherwise. Period = half cycles.

When `en[i]` = 0:
- Counter holds.
- Square mode: `out[i]` holds its level.
- Tick mode: `out[i]` = 0.
- Re-enabling resumes from the held count.

Config handshake:
- `cfg_ready` = NOT `pending[cfg_ch]` (combinational).
- Accept when `cfg_valid && cfg_ready`: `cfg_half`/`cfg_mode` are captured into the channel's shadow register and `pending` is set.
- Enabled channel: shadow is applied at the first terminal count strictly after the accept cycle. The counter wraps to 0 and counts against the new half.
  - If the mode changes, `out[i]` is forced to 0 instead of toggling or ticking.
  - If the mode is unchanged, the normal terminal action occurs.
- Disabled channel: shadow is applied on the cycle after accept; counter cleared to 0, `out[i]` = 0.
- `cfg_half` of 0 is stored as 1. With half = 1, square mode toggles every cycle and tick mode holds `out` = 1 continuously.
- Accept and terminal count in the same cycle: that terminal uses the old settings.

## Timing

- `out` is registered and changes on the same edge at which the counter wraps.
- From reset release with `en[i]` = 1 and half = H: the first square toggle or tick occurs on the H-th rising edge.
- Config apply latency: at most 1 + H_old cycles for an enabled channel; 1 cycle for a disabled channel.
- `cfg_ready` for a channel returns high on the cycle after its shadow is applied.

## Configuration

Macro `MULTI_PERIOD_PULSE_GEN_SYNC_EN`:
- **Defined:** `sync` high on an edge:
  - Every channel's counter is set to 0 and `out` to 0.
  - Any pending shadows are applied.
  - This has priority over terminal count and over a same-cycle accept; an accept in that cycle is applied at the next terminal.
- **Undefined:** `sync` is ignored and the related logic is compiled out. The port remains for interface stability.

## Structure

Package `pulse_gen_pkg`:
- `pulse_mode_e` enum: `MODE_SQUARE` = 0, `MODE_TICK` = 1.
- Default `CNT_W` and `DEFAULT_HALF` constants.
- Clamp-to-1 helper function.

Sub-module `pulse_gen_channel`:
- Contains one counter, active half/mode, shadow, pending flag and output flop.
- Instantiated `NUM_CH` times in a generate loop.
- Top level keeps only the `cfg_ch` decode, the `cfg_ready` mux and `sync` fan-out.

## Test plan

- Reset release, `en` = 4'b0001, `DEFAULT_HALF` overridden to 4 -> `out[0]` toggles at edges 4, 8, 12; `out[3:1]` stay 0.
- Channel 1, tick mode, half = 3, enabled -> `out[1]` high for one cycle at edges 3, 6, 9.
- Enabled channel 0 (half 4, square): reconfigure to half = 2 at count 1 -> `cfg_ready` drops; old wrap at count 3; then toggles every 2 cycles; `cfg_ready` high again.
- Second `cfg_valid` to the same pending channel -> not accepted until apply. Concurrent request to another channel -> accepted immediately.
- `cfg_half` = 0 in square mode -> `out` toggles every cycle. Drop `en` mid-count -> count and `out` hold; resume finishes the remaining cycles.
- With `MULTI_PERIOD_PULSE_GEN_SYNC_EN`: `sync` pulse -> all `out` = 0 and counters restart aligned; assert `rst` mid-count -> outputs 0 immediately, without waiting for a clock edge.
